// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier producing a 2*WIDTH product with HI/LO load pulses.
// Optional unsigned (multu) support is enabled by defining BOOTH_MULT_UNSIGNED_EN.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
`ifdef BOOTH_MULT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hi_load,
  output logic             lo_load,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   p_hi;
  logic [WIDTH:0]   p_lo;
  logic             q1;
  logic             uns_q;
  logic [CW-1:0]    cnt;

  logic             start_uns;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   p_hi_nx;
  logic [WIDTH:0]   p_lo_nx;
  logic [WIDTH-1:0] hi_nx;
  logic [WIDTH-1:0] lo_nx;

`ifdef BOOTH_MULT_UNSIGNED_EN
  assign start_uns = is_unsigned;
`else
  assign start_uns = 1'b0;
`endif

  // One Booth step; p_lo carries an extra top bit so the unsigned path can
  // run one more iteration over the zero-extended multiplier.
  always_comb begin
    sum = p_hi;
    case ({p_lo[0], q1})
      2'b01:   sum = p_hi + a_q;
      2'b10:   sum = p_hi - a_q;
      default: sum = p_hi;
    endcase
    p_hi_nx = {sum[WIDTH], sum[WIDTH:1]};
    p_lo_nx = {sum[0], p_lo[WIDTH:1]};
    if (uns_q) begin
      hi_nx = {p_hi_nx[WIDTH-2:0], p_lo_nx[WIDTH]};
      lo_nx = p_lo_nx[WIDTH-1:0];
    end else begin
      // Signed path stops one shift short: the unused sign bit sits in p_lo[0].
      hi_nx = p_hi_nx[WIDTH-1:0];
      lo_nx = p_lo_nx[WIDTH:1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= StIdle;
      a_q     <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      q1      <= 1'b0;
      uns_q   <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_load <= 1'b0;
      lo_load <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else if (clear) begin
      state   <= StIdle;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi_load <= 1'b0;
      lo_load <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      case (state)
        StIdle: begin
          done    <= 1'b0;
          hi_load <= 1'b0;
          lo_load <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            state <= StRun;
            busy  <= 1'b1;
            uns_q <= start_uns;
            a_q   <= start_uns ? {1'b0, op_a} : {op_a[WIDTH-1], op_a};
            p_lo  <= start_uns ? {1'b0, op_b} : {op_b[WIDTH-1], op_b};
            p_hi  <= '0;
            q1    <= 1'b0;
            cnt   <= start_uns ? CW'(WIDTH + 1) : CW'(WIDTH);
          end
        end
        StRun: begin
          p_hi <= p_hi_nx;
          p_lo <= p_lo_nx;
          q1   <= p_lo[0];
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state   <= StDone;
            done    <= 1'b1;
            hi_load <= 1'b1;
            lo_load <= 1'b1;
            hi_out  <= hi_nx;
            lo_out  <= lo_nx;
          end
        end
        StDone: begin
          state   <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          hi_load <= 1'b0;
          lo_load <= 1'b0;
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: scoreboard of expected products, per-scenario tasks.
// Covers the unsigned path when BOOTH_MULT_UNSIGNED_EN is defined.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        is_unsigned = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, hi_load, lo_load;
  logic [31:0] hi_out, lo_out;

  int npass = 0;
  int ntotal = 0;
  logic [63:0] exp_q[$];

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .start       (start),
`ifdef BOOTH_MULT_UNSIGNED_EN
    .is_unsigned (is_unsigned),
`endif
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .hi_load     (hi_load),
    .lo_load     (lo_load),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input bit uns);
    longint sa, sb;
    if (uns) return {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Drives a one-cycle start, pushes the expected product; returns at the negedge of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit uns);
    @(negedge clk);
    op_a = a;
    op_b = b;
    is_unsigned = uns;
    start = 1'b1;
    exp_q.push_back(model(a, b, uns));
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    is_unsigned = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc = 1;
    seen = 1'b0;
    while (cyc < 80) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done || hi_load || lo_load) cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    ntotal++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else npass++;
    ntotal++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else npass++;
    ntotal++;
    if ({hi_load, lo_load} !== 2'b00) $display("FAIL reset_load got %b want 00", {hi_load, lo_load});
    else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== 64'h0) $display("FAIL reset_out got %h want 0", {hi_out, lo_out});
    else npass++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int cyc;
    bit seen;
    logic [63:0] exp_v;
    issue(32'd7, 32'hFFFF_FFFD, 1'b0);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++; if (cyc !== 33) $display("FAIL basic_latency got %0d want 33", cyc); else npass++;
    ntotal++;
    if ({hi_load, lo_load} !== 2'b11) $display("FAIL basic_load got %b want 11", {hi_load, lo_load});
    else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL basic_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    @(negedge clk);
    ntotal++;
    if ({done, hi_load, lo_load} !== 3'b000)
      $display("FAIL basic_pulse_width got %b want 000", {done, hi_load, lo_load});
    else npass++;
    ntotal++; if (busy !== 1'b0) $display("FAIL basic_busy_after got %b want 0", busy); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL basic_hold got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] av[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0, 32'h1234_5678, 32'h0};
    logic [31:0] bv[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'h9ABC_DEF0, 32'h0};
    int cyc;
    bit seen;
    logic [63:0] exp_v;
    av[5] = $urandom;
    bv[5] = $urandom;
    for (int i = 0; i < 6; i++) begin
      issue(av[i], bv[i], 1'b0);
      wait_done(cyc, seen);
      exp_v = exp_q.pop_front();
      ntotal++; if (cyc !== 33) $display("FAIL b2b_latency[%0d] got %0d want 33", i, cyc); else npass++;
      ntotal++;
      if ({hi_out, lo_out} !== exp_v)
        $display("FAIL b2b_prod[%0d] got %h want %h", i, {hi_out, lo_out}, exp_v);
      else npass++;
    end
  endtask

  task automatic test_start_ignored;
    int cyc;
    int extra;
    bit busy_ok;
    logic [63:0] exp_v;
    issue(32'h0001_2345, 32'hFEDC_BA98, 1'b0);
    cyc = 1;
    busy_ok = 1'b1;
    while (cyc < 80 && !done) begin
      if (!busy) busy_ok = 1'b0;
      start = (cyc == 5 || cyc == 20);
      op_a = $urandom;
      op_b = $urandom;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    exp_v = exp_q.pop_front();
    ntotal++; if (busy_ok !== 1'b1) $display("FAIL ign_busy got 0 want 1 throughout"); else npass++;
    ntotal++; if (cyc !== 33) $display("FAIL ign_latency got %0d want 33", cyc); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL ign_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    count_dones(40, extra);
    ntotal++; if (extra !== 0) $display("FAIL ign_extra_done got %0d want 0", extra); else npass++;
  endtask

  task automatic test_clear;
    int cyc;
    int extra;
    bit seen;
    logic [63:0] exp_v;
    issue(32'hDEAD_BEEF, 32'h0000_1001, 1'b0);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_v = exp_q.pop_front();
    ntotal++; if (busy !== 1'b0) $display("FAIL clr_busy got %b want 0", busy); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== 64'h0) $display("FAIL clr_out got %h want 0", {hi_out, lo_out});
    else npass++;
    count_dones(40, extra);
    ntotal++; if (extra !== 0) $display("FAIL clr_no_done got %0d want 0", extra); else npass++;
    issue(32'hFFFF_FF9C, 32'd12345, 1'b0);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++; if (cyc !== 33) $display("FAIL clr_fresh_latency got %0d want 33", cyc); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v)
      $display("FAIL clr_fresh_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    ntotal++; if (busy !== 1'b0) $display("FAIL clr_start_busy got %b want 0", busy); else npass++;
    count_dones(40, extra);
    ntotal++; if (extra !== 0) $display("FAIL clr_start_done got %0d want 0", extra); else npass++;
  endtask

  task automatic test_clear_done;
    int cyc;
    bit seen;
    logic [63:0] exp_v;
    issue(32'h0000_0100, 32'h0000_0300, 1'b0);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    clear = 1'b1;
    ntotal++;
    if ({done, hi_load} !== 2'b11) $display("FAIL cd_pulse got %b want 11", {done, hi_load});
    else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL cd_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    @(negedge clk);
    clear = 1'b0;
    ntotal++;
    if ({hi_out, lo_out} !== 64'h0) $display("FAIL cd_zeroed got %h want 0", {hi_out, lo_out});
    else npass++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int extra;
    bit seen;
    logic [63:0] exp_v;
    issue(32'h0BAD_F00D, 32'h0000_0777, 1'b0);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL rm_pre_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    issue(32'h1111_2222, 32'h3333_4444, 1'b0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    ntotal++;
    if ({busy, done, hi_load, lo_load} !== 4'b0000)
      $display("FAIL rm_ctrl got %b want 0000", {busy, done, hi_load, lo_load});
    else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== 64'h0) $display("FAIL rm_out got %h want 0", {hi_out, lo_out});
    else npass++;
    @(negedge clk);
    reset = 1'b0;
    count_dones(40, extra);
    ntotal++; if (extra !== 0) $display("FAIL rm_no_pulse got %0d want 0", extra); else npass++;
  endtask

`ifdef BOOTH_MULT_UNSIGNED_EN
  task automatic test_unsigned;
    int cyc;
    bit seen;
    logic [63:0] exp_v;
    issue(32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++; if (cyc !== 34) $display("FAIL uns_latency got %0d want 34", cyc); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL uns_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    issue(32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++; if (cyc !== 33) $display("FAIL sgn_latency got %0d want 33", cyc); else npass++;
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL sgn_prod got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
    issue(32'h8000_0001, 32'hFFFF_FFFE, 1'b1);
    wait_done(cyc, seen);
    exp_v = exp_q.pop_front();
    ntotal++;
    if ({hi_out, lo_out} !== exp_v) $display("FAIL uns_big got %h want %h", {hi_out, lo_out}, exp_v);
    else npass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_clear();
    test_clear_done();
    test_reset_mid();
`ifdef BOOTH_MULT_UNSIGNED_EN
    test_unsigned();
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
